// File: rtl/fx3_slfifo_reader.sv
// rtl/fx3_slfifo_reader.sv - FX3 synchronous slave-FIFO burst reader with read-latency realignment
//
// Purpose: issues burst reads from one FX3 socket and delivers the returned words, in
// order, to an internal consumer. Each issued read is tagged in a valid pipe. The tag
// emerges in the same cycle that the registered DQ sample of that read is presented.
//
// Ports:
//   clk, grst            clock (same as PCLK), synchronous active-high reset
//   i_en                 read enable (low stops new bursts and ends a running one)
//   fx3_flaga/flagb      socket ready / active-low watermark flag
//   fx3_dq               FX3 data bus (registered on entry)
//   fx3_a, fx3_slcs_n,
//   fx3_sloe_n,
//   fx3_slrd_n           registered FX3 control outputs
//   i_afull              consumer almost-full throttle
//   o_data, o_valid      delivered word and its one-cycle qualifier
//   o_burst_done         one-cycle pulse when a burst has fully drained
//   o_busy               high whenever the FSM is outside IDLE
module fx3_slfifo_reader #(
  parameter int         DW      = 16,
  parameter logic [1:0] RD_ADDR = 2'b11,
  parameter int         BURST   = 256,
  parameter int         RD_LAT  = 2
) (
  input  logic          clk,
  input  logic          grst,
  input  logic          i_en,
  input  logic          fx3_flaga,
  input  logic          fx3_flagb,
  input  logic [DW-1:0] fx3_dq,
  output logic [1:0]    fx3_a,
  output logic          fx3_slcs_n,
  output logic          fx3_sloe_n,
  output logic          fx3_slrd_n,
  input  logic          i_afull,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_burst_done,
  output logic          o_busy
);

  localparam int CW  = $clog2(BURST + 1);
  localparam int DCW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      a_q, a_d;
  logic            cs_n_q, cs_n_d;
  logic            oe_n_q, oe_n_d;
  logic            rd_n_q, rd_n_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic [RD_LAT:0] vpipe_q, vpipe_d;
  logic [DW-1:0]   dq_q, dq_d;
  logic            stop;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cs_n_d  = cs_n_q;
    oe_n_d  = oe_n_q;
    rd_n_d  = 1'b1;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    dq_d    = fx3_dq;

    // A cycle with the strobe low at the pin is one issued read.
    if (!rd_n_q) cnt_d = cnt_q + CW'(1);

    // The read issued this cycle is the last one if any stop criterion is seen now.
    stop = ((cnt_q + CW'(1)) == CW'(BURST)) || !fx3_flagb || i_afull || !i_en;

    // Tag pipe: stage RD_LAT lines up with the input-registered DQ of that read.
    vpipe_d[0] = !rd_n_q;
    for (int i = 1; i <= RD_LAT; i++) vpipe_d[i] = vpipe_q[i-1];

    unique case (state_q)
      IDLE: begin
        if (i_en && fx3_flaga && !i_afull) begin
          state_d = ADDR;
          a_d     = RD_ADDR;
          cs_n_d  = 1'b0;
          oe_n_d  = 1'b0;
        end
      end
      ADDR: begin
        // Bus-turnaround cycle; the strobe goes low from READ entry.
        state_d = READ;
        rd_n_d  = 1'b0;
      end
      READ: begin
        if (stop) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          rd_n_d  = 1'b0;
        end
      end
      DRAIN: begin
        // Keep the socket selected until the last in-flight word is captured.
        if (dcnt_q == DCW'(RD_LAT)) begin
          state_d = IDLE;
          a_d     = 2'b00;
          cs_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          dcnt_d  = dcnt_q + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q <= IDLE;
      a_q     <= 2'b00;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      vpipe_q <= '0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      rd_n_q  <= rd_n_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      vpipe_q <= vpipe_d;
      dq_q    <= dq_d;
    end
  end

  assign fx3_a        = a_q;
  assign fx3_slcs_n   = cs_n_q;
  assign fx3_sloe_n   = oe_n_q;
  assign fx3_slrd_n   = rd_n_q;
  assign o_data       = dq_q;
  assign o_valid      = vpipe_q[RD_LAT];
  assign o_burst_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_fx3_slfifo_reader.sv
// tb/tb_fx3_slfifo_reader.sv - directed self-checking bench for fx3_slfifo_reader
module tb_fx3_slfifo_reader;

  localparam int DW     = 16;
  localparam int BURST  = 8;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          grst = 1'b1;
  logic          i_en = 1'b0;
  logic          fx3_flaga = 1'b0;
  logic          fx3_flagb = 1'b1;
  logic [DW-1:0] fx3_dq = '0;
  logic [1:0]    fx3_a;
  logic          fx3_slcs_n, fx3_sloe_n, fx3_slrd_n;
  logic          i_afull = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_burst_done, o_busy;

  fx3_slfifo_reader #(.DW(DW), .RD_ADDR(2'b11), .BURST(BURST), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .grst(grst), .i_en(i_en), .fx3_flaga(fx3_flaga), .fx3_flagb(fx3_flagb),
    .fx3_dq(fx3_dq), .fx3_a(fx3_a), .fx3_slcs_n(fx3_slcs_n), .fx3_sloe_n(fx3_sloe_n),
    .fx3_slrd_n(fx3_slrd_n), .i_afull(i_afull), .o_data(o_data), .o_valid(o_valid),
    .o_burst_done(o_burst_done), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int   errors = 0, checks = 0;
  int   cyc = 0, n_rd = 0, n_val = 0, n_done = 0, n_cs = 0;
  int   first_rd = -1, first_val = -1;
  int   rd_data = 0, exp_data = 0, v0;
  logic hist [0:RD_LAT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_rd = 0; n_val = 0; n_done = 0; n_cs = 0; first_rd = -1; first_val = -1;
  endtask

  // One clock; then sample outputs and play the FX3 side: a read issued in cycle c
  // puts the next ramp value on DQ in cycle c+RD_LAT.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = RD_LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = !fx3_slrd_n;
    if (hist[RD_LAT]) begin
      fx3_dq = DW'(rd_data);
      rd_data++;
    end else begin
      fx3_dq = 16'hdead;
    end
    if (!fx3_slrd_n) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (!fx3_slcs_n) n_cs++;
    if (o_valid) begin
      chk("o_data", 32'(o_data), 32'(exp_data));
      exp_data++;
      n_val++;
      if (first_val < 0) first_val = cyc;
    end
    if (o_burst_done) n_done++;
  endtask

  task automatic wait_reads(input int k);
    int t = 0;
    while (n_rd < k && t < 60) begin
      step();
      t++;
    end
    chk("wait_reads", 32'(n_rd >= k), 32'd1);
  endtask

  initial begin
    for (int i = 0; i <= RD_LAT; i++) hist[i] = 1'b0;

    // Reset state
    step(); step();
    chk("rst_cs_n", 32'(fx3_slcs_n), 32'd1);
    chk("rst_oe_n", 32'(fx3_sloe_n), 32'd1);
    chk("rst_rd_n", 32'(fx3_slrd_n), 32'd1);
    chk("rst_a", 32'(fx3_a), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_done", 32'(o_burst_done), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    grst = 1'b0; i_en = 1'b1;
    step();
    clr_counts();

    // 1: full burst of BURST words
    fx3_flaga = 1'b1;
    step();
    chk("t1_addr_a", 32'(fx3_a), 32'd3);
    chk("t1_addr_cs", 32'(fx3_slcs_n), 32'd0);
    chk("t1_addr_rd", 32'(fx3_slrd_n), 32'd1);
    chk("t1_busy", 32'(o_busy), 32'd1);
    fx3_flaga = 1'b0;
    step();
    chk("t1_read_rd", 32'(fx3_slrd_n), 32'd0);
    repeat (25) step();
    chk("t1_reads", 32'(n_rd), 32'd8);
    chk("t1_valids", 32'(n_val), 32'd8);
    chk("t1_latency", 32'(first_val - first_rd), 32'(RD_LAT + 1));
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_last_word", 32'(exp_data), 32'd8);

    // 2: flagb drops when the 3rd read is on the bus
    clr_counts();
    fx3_flaga = 1'b1;
    step();
    fx3_flaga = 1'b0;
    wait_reads(3);
    fx3_flagb = 1'b0;
    step();
    chk("t2_rd_high", 32'(fx3_slrd_n), 32'd1);
    chk("t2_drain1_cs", 32'(fx3_slcs_n), 32'd0);
    step();
    chk("t2_drain2_cs", 32'(fx3_slcs_n), 32'd0);
    step();
    chk("t2_drain3_oe", 32'(fx3_sloe_n), 32'd0);
    step();
    chk("t2_idle_cs", 32'(fx3_slcs_n), 32'd1);
    chk("t2_idle_oe", 32'(fx3_sloe_n), 32'd1);
    chk("t2_done", 32'(o_burst_done), 32'd1);
    fx3_flagb = 1'b1;
    repeat (5) step();
    chk("t2_reads", 32'(n_rd), 32'd3);
    chk("t2_valids", 32'(n_val), 32'd3);

    // 3: almost-full at read 5, flaga held high throughout
    clr_counts();
    fx3_flaga = 1'b1;
    step();
    wait_reads(5);
    i_afull = 1'b1;
    repeat (20) step();
    chk("t3_reads", 32'(n_rd), 32'd5);
    chk("t3_valids", 32'(n_val), 32'd5);
    chk("t3_idle", 32'(o_busy), 32'd0);
    i_afull = 1'b0;
    step();
    chk("t3_restart", 32'(o_busy), 32'd1);
    fx3_flaga = 1'b0;
    repeat (25) step();
    chk("t3_reads2", 32'(n_rd), 32'd13);
    chk("t3_valids2", 32'(n_val), 32'd13);

    // 4: reset with two words in flight
    clr_counts();
    fx3_flaga = 1'b1;
    step();
    fx3_flaga = 1'b0;
    wait_reads(2);
    grst = 1'b1;
    step();
    chk("t4_rd_n", 32'(fx3_slrd_n), 32'd1);
    chk("t4_cs_n", 32'(fx3_slcs_n), 32'd1);
    chk("t4_oe_n", 32'(fx3_sloe_n), 32'd1);
    chk("t4_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i <= RD_LAT; i++) hist[i] = 1'b0;
    exp_data = rd_data;
    v0 = n_val;
    grst = 1'b0;
    repeat (10) step();
    chk("t4_no_stale", 32'(n_val), 32'(v0));
    chk("t4_idle", 32'(o_busy), 32'd0);
    clr_counts();
    fx3_flaga = 1'b1;
    step();
    chk("t4_fresh", 32'(fx3_a), 32'd3);
    fx3_flaga = 1'b0;
    repeat (25) step();
    chk("t4_reads", 32'(n_rd), 32'd8);
    chk("t4_valids", 32'(n_val), 32'd8);
    chk("t4_done", 32'(n_done), 32'd1);

    // 5: socket not ready, then ready; i_en drop ends burst after one read
    clr_counts();
    repeat (100) step();
    chk("t5_no_cs", 32'(n_cs), 32'd0);
    chk("t5_no_rd", 32'(n_rd), 32'd0);
    fx3_flaga = 1'b1;
    step();
    chk("t5_addr_cs", 32'(fx3_slcs_n), 32'd0);
    chk("t5_addr_rd", 32'(fx3_slrd_n), 32'd1);
    step();
    chk("t5_read_rd", 32'(fx3_slrd_n), 32'd0);
    fx3_flaga = 1'b0;
    i_en = 1'b0;
    repeat (10) step();
    chk("t5_reads", 32'(n_rd), 32'd1);
    chk("t5_valids", 32'(n_val), 32'd1);
    chk("t5_done", 32'(n_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
